reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 91 +++++++++
 tb/tb_reg_file_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file: 1 write port, 2 combinational read ports, per-register pending bits.
// Optional same-cycle write-to-read bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_param #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  output logic             rd_busy1,
  output logic             rd_busy2
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic wr_ok;
  logic set_ok;

  assign wr_ok  = wen && (wr_addr != '0);
  assign set_ok = busy_set && (busy_addr != '0);

  // Next state: a write retires the pending producer, a new busy_set applied last so it wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      pend_d[busy_addr] = 1'b1;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read port 1; outputs forced low while reset is asserted.
  always_comb begin
    rd_data1 = '0;
    rd_busy1 = 1'b0;
    if (!rst && (rd_addr1 != '0)) begin
      rd_data1 = regs_q[rd_addr1];
      rd_busy1 = pend_q[rd_addr1];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (rd_addr1 == wr_addr)) begin
        rd_data1 = wr_data;
        rd_busy1 = busy_set && (busy_addr == wr_addr);
      end
`endif
    end
  end

  // Read port 2; mirrors port 1.
  always_comb begin
    rd_data2 = '0;
    rd_busy2 = 1'b0;
    if (!rst && (rd_addr2 != '0)) begin
      rd_data2 = regs_q[rd_addr2];
      rd_busy2 = pend_q[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (rd_addr2 == wr_addr)) begin
        rd_data2 = wr_data;
        rd_busy2 = busy_set && (busy_addr == wr_addr);
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed scenarios plus randomized traffic vs. an array model.
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-size instance (16 x 16)
  logic        a_rst, a_wen, a_bs, a_rb1, a_rb2;
  logic [3:0]  a_wa, a_ba, a_ra1, a_ra2;
  logic [15:0] a_wd, a_rd1, a_rd2;

  reg_file_param dut_a (
    .clk(clk), .rst(a_rst), .wen(a_wen), .wr_addr(a_wa), .wr_data(a_wd),
    .rd_addr1(a_ra1), .rd_data1(a_rd1), .rd_addr2(a_ra2), .rd_data2(a_rd2),
    .busy_set(a_bs), .busy_addr(a_ba), .rd_busy1(a_rb1), .rd_busy2(a_rb2)
  );

  // Wide instance (32 x 32)
  logic        b_rst, b_wen, b_bs, b_rb1, b_rb2;
  logic [4:0]  b_wa, b_ba, b_ra1, b_ra2;
  logic [31:0] b_wd, b_rd1, b_rd2;

  reg_file_param #(.WIDTH(32), .DEPTH(32)) dut_b (
    .clk(clk), .rst(b_rst), .wen(b_wen), .wr_addr(b_wa), .wr_data(b_wd),
    .rd_addr1(b_ra1), .rd_data1(b_rd1), .rd_addr2(b_ra2), .rd_data2(b_rd2),
    .busy_set(b_bs), .busy_addr(b_ba), .rd_busy1(b_rb1), .rd_busy2(b_rb2)
  );

  // Reference model of the 16 x 16 file
  logic [15:0] mem  [16];
  bit          pend [16];

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [15:0] exp_data(input logic [3:0] addr);
    if (a_rst) return 16'h0;
    if (BYPASS && a_wen && a_wa != 0 && addr == a_wa) return a_wd;
    return mem[addr];
  endfunction

  function automatic logic exp_busy(input logic [3:0] addr);
    if (a_rst) return 1'b0;
    if (BYPASS && a_wen && a_wa != 0 && addr == a_wa) return a_bs && (a_ba == a_wa);
    return pend[addr];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive A inputs mid-cycle and compare all four read outputs with the model.
  task automatic apply(input logic r, input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic bs, input logic [3:0] ba, input logic [3:0] r1, input logic [3:0] r2);
    a_rst = r; a_wen = w; a_wa = wa; a_wd = wd; a_bs = bs; a_ba = ba; a_ra1 = r1; a_ra2 = r2;
    #2;
    chk("rd_data1", 32'(a_rd1), 32'(exp_data(a_ra1)));
    chk("rd_data2", 32'(a_rd2), 32'(exp_data(a_ra2)));
    chk("rd_busy1", 32'(a_rb1), 32'(exp_busy(a_ra1)));
    chk("rd_busy2", 32'(a_rb2), 32'(exp_busy(a_ra2)));
  endtask

  // Clock edge: the model applies the register-file rules to the held inputs.
  task automatic tick();
    @(posedge clk);
    if (a_rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  = 16'h0;
        pend[i] = 1'b0;
      end
    end else begin
      if (a_wen && a_wa != 0) begin
        mem[a_wa]  = a_wd;
        pend[a_wa] = 1'b0;
      end
      if (a_bs && a_ba != 0) pend[a_ba] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] r1, input logic [3:0] r2);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, r1, r2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 16'h0;
      pend[i] = 1'b0;
    end
    b_rst = 1'b1; b_wen = 1'b0; b_wa = '0; b_wd = '0; b_bs = 1'b0; b_ba = '0; b_ra1 = '0; b_ra2 = '0;

    // Reset, then read every address on both ports
    apply(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      idle(4'(i), 4'(15 - i));
      chk("reset_data", 32'(a_rd1), 32'h0);
      chk("reset_busy", 32'(a_rb2), 32'h0);
    end

    // Write 0xBEEF to reg 5; write to reg 0 ignored
    apply(1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd1, 4'd2);
    tick();
    idle(4'd5, 4'd5);
    chk("beef_p1", 32'(a_rd1), 32'hBEEF);
    chk("beef_p2", 32'(a_rd2), 32'hBEEF);
    apply(1'b0, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 4'd6, 4'd6);
    tick();
    idle(4'd0, 4'd5);
    chk("reg0_zero", 32'(a_rd1), 32'h0);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0, 4'd0);
    tick();
    idle(4'd0, 4'd0);
    chk("reg0_busy", 32'(a_rb1), 32'h0);

    // Busy set then cleared by the producer's write
    apply(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd1, 4'd1);
    tick();
    idle(4'd3, 4'd0);
    chk("busy3_set", 32'(a_rb1), 32'h1);
    apply(1'b0, 1'b1, 4'd3, 16'h00AA, 1'b0, 4'd0, 4'd1, 4'd1);
    tick();
    idle(4'd3, 4'd3);
    chk("busy3_clr", 32'(a_rb1), 32'h0);
    chk("data3", 32'(a_rd1), 32'h00AA);

    // Simultaneous set and write to the same register: set wins
    apply(1'b0, 1'b1, 4'd7, 16'h0F0F, 1'b1, 4'd7, 4'd1, 4'd1);
    tick();
    idle(4'd7, 4'd7);
    chk("setwin_data", 32'(a_rd2), 32'h0F0F);
    chk("setwin_busy", 32'(a_rb2), 32'h1);

    // Set and write to different registers
    apply(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd8, 4'd1, 4'd1);
    tick();
    apply(1'b0, 1'b1, 4'd8, 16'h5A5A, 1'b1, 4'd10, 4'd1, 4'd1);
    tick();
    idle(4'd8, 4'd10);
    chk("diff_clr", 32'(a_rb1), 32'h0);
    chk("diff_set", 32'(a_rb2), 32'h1);

    // Same-cycle read of the register being written
    apply(1'b0, 1'b1, 4'd9, 16'h1111, 1'b0, 4'd0, 4'd1, 4'd1);
    tick();
    apply(1'b0, 1'b1, 4'd9, 16'h2222, 1'b0, 4'd0, 4'd9, 4'd2);
    chk("bypass_data", 32'(a_rd1), BYPASS ? 32'h2222 : 32'h1111);
    tick();
    idle(4'd9, 4'd9);
    chk("after_write", 32'(a_rd1), 32'h2222);

    // Reset overrides write and busy_set
    apply(1'b0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 4'd1, 4'd1);
    tick();
    apply(1'b1, 1'b1, 4'd4, 16'hFFFF, 1'b1, 4'd4, 4'd4, 4'd4);
    chk("rst_cycle", 32'(a_rd1), 32'h0);
    tick();
    idle(4'd4, 4'd7);
    chk("rst_data4", 32'(a_rd1), 32'h0);
    chk("rst_busy4", 32'(a_rb1), 32'h0);
    chk("rst_busy7", 32'(a_rb2), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic       r, w, bs;
      logic [3:0] wa, ba, r1, r2;
      r  = ($urandom_range(0, 39) == 0);
      w  = 1'($urandom_range(0, 1));
      bs = ($urandom_range(0, 2) == 0);
      wa = 4'($urandom);
      ba = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? ba : 4'($urandom);
      apply(r, w, wa, 16'($urandom), bs, ba, r1, r2);
      tick();
    end
    idle(4'd0, 4'd0);

    // Wide instance: reset, write top register, reg 0 stays zero
    #2;
    chk("b_rst_data", b_rd1, 32'h0);
    @(posedge clk); #1;
    b_rst = 1'b0; b_ra1 = 5'd31; b_ra2 = 5'd17;
    #2;
    chk("b_reset31", b_rd1, 32'h0);
    chk("b_resetbusy", 32'(b_rb2), 32'h0);
    b_wen = 1'b1; b_wa = 5'd31; b_wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    b_wen = 1'b0; b_ra2 = 5'd31;
    #2;
    chk("b_p1_31", b_rd1, 32'hDEADBEEF);
    chk("b_p2_31", b_rd2, 32'hDEADBEEF);
    b_wen = 1'b1; b_wa = 5'd0; b_wd = 32'h00001234;
    @(posedge clk); #1;
    b_wen = 1'b0; b_ra1 = 5'd0;
    #2;
    chk("b_reg0", b_rd1, 32'h0);
    b_bs = 1'b1; b_ba = 5'd31;
    @(posedge clk); #1;
    b_bs = 1'b0;
    #2;
    chk("b_busy31", 32'(b_rb2), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
